// File: rtl/fat32_write_sequencer_if.sv
// Request/status and SD sector-write signals shared between the FAT32 write sequencer and its
// environment.
interface fat32_write_sequencer_if;
   logic        start;
   logic [31:0] file_sectors;
   logic [15:0] reserved_sectors;
   logic [31:0] fat_length;
   logic [8:0]  num_fat;
   logic        busy;
   logic        done;
   logic        err;
   logic        sd_wr_req;
   logic [31:0] sd_wr_addr;
   logic [1:0]  sd_wr_kind;
   logic        sd_wr_ack;
   logic        sd_wr_done;
   logic [24:0] fat_sector_idx;
   logic [31:0] first_cluster;
   logic [31:0] last_cluster;
   logic [31:0] file_size_bytes;

   modport slave (
      input  start, file_sectors, reserved_sectors, fat_length, num_fat, sd_wr_ack, sd_wr_done,
      output busy, done, err, sd_wr_req, sd_wr_addr, sd_wr_kind, fat_sector_idx,
             first_cluster, last_cluster, file_size_bytes
   );

   modport master (
      output start, file_sectors, reserved_sectors, fat_length, num_fat, sd_wr_ack, sd_wr_done,
      input  busy, done, err, sd_wr_req, sd_wr_addr, sd_wr_kind, fat_sector_idx,
             first_cluster, last_cluster, file_size_bytes
   );
endinterface

// File: rtl/fat32_write_sequencer.sv
// Drives one FAT32 file write: data sectors, FAT sectors for every FAT copy, then the root
// directory sector, each through the shared SD sector-write handshake.
module fat32_write_sequencer #(
   parameter int unsigned SECTORS_PER_CLUSTER = 8,
   parameter int unsigned FIRST_CLUSTER       = 3
) (
   input logic                    clk,
   input logic                    rst_n,
   fat32_write_sequencer_if.slave bus
);
   localparam int unsigned SpcLog2 = $clog2(SECTORS_PER_CLUSTER);
   localparam logic [31:0] FirstCl = 32'(FIRST_CLUSTER);
   localparam logic [31:0] BaseOff = 32'((FIRST_CLUSTER - 2) * SECTORS_PER_CLUSTER);
   localparam logic [31:0] SpcM1   = 32'(SECTORS_PER_CLUSTER - 1);
   localparam logic [24:0] FatLo   = 25'(FIRST_CLUSTER >> 7);

   typedef enum logic [3:0] {
      StIdle, StCalc, StDataReq, StDataWait, StFatReq, StFatWait, StDirReq, StDirWait, StDone
   } state_e;

   state_e      state_q;
   logic [31:0] fs_q, fl_q;
   logic [15:0] res_q;
   logic [8:0]  nf_q;
   logic        err_flag_q;
   logic [31:0] root_q, data_base_q, data_cnt_q, fat_off_q;
   logic [24:0] fat_hi_q, fat_s_q;
   logic [8:0]  fat_c_q;
   logic        busy_q, done_q, err_q, req_q;
   logic [31:0] addr_q;
   logic [1:0]  kind_q;
   logic [24:0] idx_q;
   logic [31:0] first_q, last_q, size_q;

   logic [40:0] fat_prod_d;
   logic [31:0] root_d, clusters_d, last_d;
   logic        calc_bad_d;

   always_comb begin
      fat_prod_d = 41'(fl_q) * 41'(nf_q);
      root_d     = 32'(res_q) + fat_prod_d[31:0];
      clusters_d = (fs_q + SpcM1) >> SpcLog2;
      last_d     = FirstCl + clusters_d - 32'd1;
      calc_bad_d = (fat_prod_d[40:32] != '0) || (fs_q[31:23] != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         fs_q        <= '0;
         fl_q        <= '0;
         res_q       <= '0;
         nf_q        <= '0;
         err_flag_q  <= 1'b0;
         root_q      <= '0;
         data_base_q <= '0;
         data_cnt_q  <= '0;
         fat_off_q   <= '0;
         fat_hi_q    <= '0;
         fat_s_q     <= '0;
         fat_c_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         req_q       <= 1'b0;
         addr_q      <= '0;
         kind_q      <= '0;
         idx_q       <= '0;
         first_q     <= '0;
         last_q      <= '0;
         size_q      <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         // busy stays up through the done/err cycle and drops one cycle later
         if (done_q || err_q) busy_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.start && !busy_q) begin
                  fs_q       <= bus.file_sectors;
                  res_q      <= bus.reserved_sectors;
                  fl_q       <= bus.fat_length;
                  nf_q       <= bus.num_fat;
                  err_flag_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= StCalc;
               end
            end
            StCalc: begin
               if (calc_bad_d) begin
                  err_flag_q <= 1'b1;
                  state_q    <= StDone;
               end else begin
                  root_q      <= root_d;
                  data_base_q <= root_d + BaseOff;
                  fat_hi_q    <= last_d[31:7];
                  size_q      <= {fs_q[22:0], 9'd0};
                  data_cnt_q  <= '0;
                  if (fs_q == '0) begin
                     first_q <= '0;
                     last_q  <= '0;
                     state_q <= StDirReq;
                  end else begin
                     first_q <= FirstCl;
                     last_q  <= last_d;
                     state_q <= StDataReq;
                  end
               end
            end
            StDataReq: begin
               addr_q <= data_base_q + data_cnt_q;
               kind_q <= 2'd0;
               if (req_q && bus.sd_wr_ack) begin
                  req_q   <= 1'b0;
                  state_q <= StDataWait;
               end else begin
                  req_q <= 1'b1;
               end
            end
            StDataWait: begin
               if (bus.sd_wr_done) begin
                  if (data_cnt_q == fs_q - 32'd1) begin
                     fat_s_q   <= FatLo;
                     fat_c_q   <= '0;
                     fat_off_q <= '0;
                     state_q   <= (nf_q == '0) ? StDirReq : StFatReq;
                  end else begin
                     data_cnt_q <= data_cnt_q + 32'd1;
                     state_q    <= StDataReq;
                  end
               end
            end
            StFatReq: begin
               addr_q <= 32'(res_q) + fat_off_q + 32'(fat_s_q);
               kind_q <= 2'd1;
               idx_q  <= fat_s_q;
               if (req_q && bus.sd_wr_ack) begin
                  req_q   <= 1'b0;
                  state_q <= StFatWait;
               end else begin
                  req_q <= 1'b1;
               end
            end
            StFatWait: begin
               if (bus.sd_wr_done) begin
                  if (fat_s_q != fat_hi_q) begin
                     fat_s_q <= fat_s_q + 25'd1;
                     state_q <= StFatReq;
                  end else if (fat_c_q == nf_q - 9'd1) begin
                     state_q <= StDirReq;
                  end else begin
                     // next FAT copy starts fat_length sectors further on
                     fat_c_q   <= fat_c_q + 9'd1;
                     fat_off_q <= fat_off_q + fl_q;
                     fat_s_q   <= FatLo;
                     state_q   <= StFatReq;
                  end
               end
            end
            StDirReq: begin
               addr_q <= root_q;
               kind_q <= 2'd2;
               if (req_q && bus.sd_wr_ack) begin
                  req_q   <= 1'b0;
                  state_q <= StDirWait;
               end else begin
                  req_q <= 1'b1;
               end
            end
            StDirWait: begin
               if (bus.sd_wr_done) state_q <= StDone;
            end
            StDone: begin
               if (err_flag_q) err_q <= 1'b1;
               else            done_q <= 1'b1;
               err_flag_q <= 1'b0;
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.err             = err_q;
   assign bus.sd_wr_req       = req_q;
   assign bus.sd_wr_addr      = addr_q;
   assign bus.sd_wr_kind      = kind_q;
   assign bus.fat_sector_idx  = idx_q;
   assign bus.first_cluster   = first_q;
   assign bus.last_cluster    = last_q;
   assign bus.file_size_bytes = size_q;
endmodule

// File: tb/tb_fat32_write_sequencer.sv
// Directed bench for fat32_write_sequencer: an engine model acks/completes sectors and checks
// each request against a queue of expected {idx, kind, addr} built from the file geometry.
module tb_fat32_write_sequencer;
   localparam int unsigned SPC   = 8;
   localparam int unsigned FIRST = 3;

   logic clk;
   logic rst_n;
   fat32_write_sequencer_if bus ();

   fat32_write_sequencer #(
      .SECTORS_PER_CLUSTER (SPC),
      .FIRST_CLUSTER       (FIRST)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_pass = 0;
   int n_total = 0;
   logic [58:0] sb[$];

   int          eng_st = 0;
   int          eng_cnt = 0;
   logic [31:0] cap_addr = '0;
   logic [1:0]  cap_kind = '0;
   int          req_cnt = 0;
   int          fat_seen = 0;
   int          ack_max = 1;
   int          done_max = 5;
   int          done_min = 0;
   bit          spurious = 1'b0;
   bit          eng_abort = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else begin
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_expected(input logic [31:0] fs, input logic [15:0] res,
                                input logic [31:0] fl, input logic [8:0] nf);
      logic [63:0] root, base, last_cl;
      root = 64'(res) + 64'(fl) * 64'(nf);
      if (fs != 0) begin
         base    = root + 64'((FIRST - 2) * SPC);
         last_cl = 64'(FIRST) + (64'(fs) + 64'(SPC) - 1) / 64'(SPC) - 1;
         for (int unsigned n = 0; n < fs; n++) sb.push_back({25'd0, 2'd0, 32'(base + 64'(n))});
         for (int unsigned c = 0; c < nf; c++)
            for (int unsigned s = FIRST / 128; s <= 32'(last_cl / 128); s++)
               sb.push_back({25'(s), 2'd1, 32'(64'(res) + 64'(c) * 64'(fl) + 64'(s))});
      end
      sb.push_back({25'd0, 2'd2, root[31:0]});
   endtask

   // SD engine model: random ack delay, random completion delay, optional spurious done.
   initial begin : engine
      logic [58:0] exp;
      bus.sd_wr_ack  = 1'b0;
      bus.sd_wr_done = 1'b0;
      forever begin
         @(negedge clk);
         bus.sd_wr_ack  = 1'b0;
         bus.sd_wr_done = 1'b0;
         if (eng_abort) begin
            eng_st = 0;
         end else if (eng_st == 2) begin
            if (eng_cnt == 0) begin
               bus.sd_wr_done = 1'b1;
               eng_st = 0;
            end else begin
               eng_cnt--;
            end
         end else begin
            if (eng_st == 0 && bus.sd_wr_req) begin
               eng_st   = 1;
               eng_cnt  = int'($urandom_range(ack_max, 0));
               cap_addr = bus.sd_wr_addr;
               cap_kind = bus.sd_wr_kind;
               req_cnt++;
            end else if (eng_st == 0 && spurious && $urandom_range(3, 0) == 0) begin
               bus.sd_wr_done = 1'b1;
            end
            if (eng_st == 1) begin
               if (spurious && $urandom_range(3, 0) == 0) bus.sd_wr_done = 1'b1;
               if (eng_cnt == 0) begin
                  bus.sd_wr_ack = 1'b1;
                  check("req_held", bus.sd_wr_req, 1'b1);
                  check("addr_stable", bus.sd_wr_addr, cap_addr);
                  check("kind_stable", bus.sd_wr_kind, cap_kind);
                  if (bus.sd_wr_kind == 2'd1) fat_seen++;
                  check("sb_nonempty", sb.size() != 0, 1'b1);
                  if (sb.size() != 0) begin
                     exp = sb.pop_front();
                     check("wr_addr", bus.sd_wr_addr, exp[31:0]);
                     check("wr_kind", bus.sd_wr_kind, exp[33:32]);
                     if (exp[33:32] == 2'd1) check("fat_idx", bus.fat_sector_idx, exp[58:34]);
                  end
                  eng_st  = 2;
                  eng_cnt = int'($urandom_range(done_max, done_min));
               end else begin
                  eng_cnt--;
               end
            end
         end
      end
   end

   task automatic pulse_start(input logic [31:0] fs, input logic [15:0] res,
                              input logic [31:0] fl, input logic [8:0] nf);
      @(negedge clk);
      bus.start            = 1'b1;
      bus.file_sectors     = fs;
      bus.reserved_sectors = res;
      bus.fat_length       = fl;
      bus.num_fat          = nf;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic recover();
      @(negedge clk);
      rst_n     = 1'b0;
      eng_abort = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      eng_abort = 1'b0;
      sb.delete();
   endtask

   task automatic run_file(input logic [31:0] fs, input logic [15:0] res, input logic [31:0] fl,
                           input logic [8:0] nf, input bit expect_err, input bit dup_start);
      int          req0, budget;
      bit          seen;
      logic [31:0] exp_last;
      req0     = req_cnt;
      exp_last = (fs == 0) ? 32'd0 : 32'(FIRST + (fs + SPC - 1) / SPC - 1);
      if (!expect_err) push_expected(fs, res, fl, nf);
      pulse_start(fs, res, fl, nf);
      check("busy_rise", bus.busy, 1'b1);
      @(negedge clk);
      check("req_lat1", bus.sd_wr_req, 1'b0);
      check("err_early", bus.err, 1'b0);
      @(negedge clk);
      if (expect_err) begin
         check("err_pulse", bus.err, 1'b1);
         check("err_no_req", bus.sd_wr_req, 1'b0);
         @(negedge clk);
         check("err_once", bus.err, 1'b0);
         check("err_busy_low", bus.busy, 1'b0);
         check("err_req_count", req_cnt - req0, 0);
      end else begin
         check("req_lat2", bus.sd_wr_req, 1'b1);
         budget = (int'(fs) + int'(nf) * 4 + 4) * (ack_max + done_max + 6) + 100;
         seen = 1'b0;
         for (int i = 0; i < budget; i++) begin
            if (dup_start && i == 5) begin
               bus.start        = 1'b1;
               bus.file_sectors = 32'd7;
            end
            if (i == 6) bus.start = 1'b0;
            @(negedge clk);
            if (bus.done) begin
               seen = 1'b1;
               break;
            end
         end
         bus.start = 1'b0;
         check("done_seen", seen, 1'b1);
         if (!seen) begin
            recover();
         end else begin
            check("busy_in_done", bus.busy, 1'b1);
            check("first_cluster", bus.first_cluster, (fs == 0) ? 32'd0 : 32'(FIRST));
            check("last_cluster", bus.last_cluster, exp_last);
            check("file_size", bus.file_size_bytes, 64'(fs) * 64'd512);
            @(negedge clk);
            check("done_once", bus.done, 1'b0);
            check("busy_fall", bus.busy, 1'b0);
            check("sb_drained", sb.size(), 0);
         end
      end
   endtask

   initial begin : main
      int fat0, req0;
      bit hit;
      rst_n                = 1'b0;
      bus.start            = 1'b0;
      bus.file_sectors     = '0;
      bus.reserved_sectors = '0;
      bus.fat_length       = '0;
      bus.num_fat          = '0;
      repeat (3) @(negedge clk);
      check("rst_req", bus.sd_wr_req, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_err", bus.err, 1'b0);
      check("rst_addr", bus.sd_wr_addr, 32'd0);
      check("rst_first", bus.first_cluster, 32'd0);
      check("rst_size", bus.file_size_bytes, 32'd0);
      rst_n = 1'b1;

      // basic file: data 2040..2049, FAT 32/1032, directory 2032
      ack_max = 1; done_max = 5;
      check("basic_first_addr", {sb.size() == 0, 32'd2040}, {1'b1, 32'd2040 + 32'(sb.size())});
      run_file(32'd10, 16'd32, 32'd1000, 9'd2, 1'b0, 1'b0);
      check("basic_last_cl", bus.last_cluster, 32'd4);
      check("basic_size", bus.file_size_bytes, 32'd5120);

      // FAT boundary around cluster 128
      ack_max = 0; done_max = 1;
      fat0 = fat_seen;
      run_file(32'd1000, 16'd32, 32'd1000, 9'd2, 1'b0, 1'b0);
      check("fat_writes_1000", fat_seen - fat0, 2);
      fat0 = fat_seen;
      run_file(32'd1001, 16'd32, 32'd1000, 9'd2, 1'b0, 1'b0);
      check("fat_writes_1001", fat_seen - fat0, 4);

      // empty file: only the directory sector
      req0 = req_cnt;
      run_file(32'd0, 16'd32, 32'd1000, 9'd2, 1'b0, 1'b0);
      check("empty_req_count", req_cnt - req0, 1);

      // no FAT copies
      fat0 = fat_seen;
      run_file(32'd9, 16'd6, 32'd77, 9'd0, 1'b0, 1'b0);
      check("nofat_writes", fat_seen - fat0, 0);

      // rejected requests: too many sectors, FAT area beyond 32 bits
      run_file(32'h0080_0000, 16'd32, 32'd1000, 9'd2, 1'b1, 1'b0);
      run_file(32'd4, 16'd32, 32'hFFFF_FFFF, 9'd2, 1'b1, 1'b0);

      // handshake stress with spurious done and a second start while busy
      ack_max = 20; done_max = 6; spurious = 1'b1;
      run_file(32'd13, 16'd100, 32'd50, 9'd3, 1'b0, 1'b1);
      run_file(32'd17, 16'd1, 32'd300, 9'd1, 1'b0, 1'b1);
      spurious = 1'b0;

      // reset while a data sector is in flight
      ack_max = 2; done_min = 8; done_max = 8;
      push_expected(32'd10, 16'd32, 32'd1000, 9'd2);
      pulse_start(32'd10, 16'd32, 32'd1000, 9'd2);
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (eng_st == 2 && cap_kind == 2'd0) begin
            hit = 1'b1;
            break;
         end
      end
      check("reach_data_wait", hit, 1'b1);
      @(negedge clk);
      rst_n     = 1'b0;
      eng_abort = 1'b1;
      @(negedge clk);
      check("midrst_req", bus.sd_wr_req, 1'b0);
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_done", bus.done, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      eng_abort = 1'b0;
      sb.delete();
      done_min = 0; done_max = 5;
      run_file(32'd10, 16'd32, 32'd1000, 9'd2, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
